// File: rtl/fifo_flagged_if.sv
// Handshake and status bundle for fifo_flagged: producer/consumer side is master, FIFO is slave.
interface fifo_flagged_if #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  WR;
    logic [DATA_WIDTH-1:0] DIN;
    logic                  RD;
    logic [DATA_WIDTH-1:0] DOUT;
    logic                  rd_valid;
    logic [ADDR_WIDTH:0]   count;
    logic                  full;
    logic                  notEmpty;
    logic                  almost_full;
    logic                  almost_empty;
    logic                  err_clr;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output WR, DIN, RD, err_clr,
        input  DOUT, rd_valid, count, full, notEmpty, almost_full, almost_empty,
               overflow, underflow
    );

    modport slave (
        input  WR, DIN, RD, err_clr,
        output DOUT, rd_valid, count, full, notEmpty, almost_full, almost_empty,
               overflow, underflow
    );
endinterface

// File: rtl/fifo_flagged.sv
// Single-clock FIFO with registered read data, occupancy count and threshold flags.
// Sticky overflow/underflow flags are built only when FIFO_ERR_FLAGS_EN is defined.
module fifo_flagged #(
    parameter int unsigned ADDR_WIDTH      = 4,
    parameter int unsigned DATA_WIDTH      = 8,
    parameter int unsigned ALMOST_FULL_TH  = 2**ADDR_WIDTH - 2,
    parameter int unsigned ALMOST_EMPTY_TH = 2
) (
    input logic           clk,
    input logic           rst,
    fifo_flagged_if.slave bus
);
    localparam int unsigned DEPTH = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_TH_C = (ADDR_WIDTH + 1)'(ALMOST_FULL_TH);
    localparam logic [ADDR_WIDTH:0] AE_TH_C = (ADDR_WIDTH + 1)'(ALMOST_EMPTY_TH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  rd_valid_q;
    logic                  rd_acc, wr_acc;

    // Status flags look only at the count register, never at this cycle's requests.
    assign bus.full         = (count_q == DEPTH_C);
    assign bus.notEmpty     = (count_q != '0);
    assign bus.almost_full  = (count_q >= AF_TH_C);
    assign bus.almost_empty = (count_q <= AE_TH_C);
    assign bus.count        = count_q;
    assign bus.DOUT         = dout_q;
    assign bus.rd_valid     = rd_valid_q;

    // No read bypass on empty; a full FIFO still takes a write when a read frees a slot.
    assign rd_acc = bus.RD & bus.notEmpty;
    assign wr_acc = bus.WR & (~bus.full | rd_acc);

    always_comb begin
        count_d = count_q;
        if (wr_acc && !rd_acc) begin
            count_d = count_q + 1'b1;
        end else if (rd_acc && !wr_acc) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            mem_q[wr_ptr_q] <= bus.DIN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            dout_q     <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                dout_q   <= mem_q[rd_ptr_q];
            end
            count_q    <= count_d;
            rd_valid_q <= rd_acc;
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    logic overflow_q, underflow_q;

    // A new error in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (bus.WR && !wr_acc) begin
                overflow_q <= 1'b1;
            end else if (bus.err_clr) begin
                overflow_q <= 1'b0;
            end
            if (bus.RD && !bus.notEmpty) begin
                underflow_q <= 1'b1;
            end else if (bus.err_clr) begin
                underflow_q <= 1'b0;
            end
        end
    end

    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = bus.err_clr;
    assign bus.overflow   = 1'b0;
    assign bus.underflow  = 1'b0;
`endif
endmodule
